// File: rtl/pio_input_irq.sv
// Avalon-MM input PIO: two-flop synchroniser, per-bit debounce, edge capture,
// interrupt mask and registered interrupt request.
module pio_input_irq #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned IRQ_TYPE        = 0,
  parameter logic [31:0] RESET_IRQMASK   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CW   = (DEBOUNCE_CYCLES <= 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TC_I = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TC = TC_I[CW-1:0];

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] deb_dly_q, deb_dly_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic             we;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] w1c;

  if (WIDTH < 32) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  assign we = chipselect && !write_n;

  always_comb begin
    s1_d      = in_port;
    s2_d      = s1_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (DEBOUNCE_CYCLES <= 1) begin
        deb_d[i] = s2_q[i];
      end else if (s2_q[i] != deb_q[i]) begin
        // A glitch back to deb resets the count via the default above.
        if (cnt_q[i] == TC) begin
          deb_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_evt = deb_q & ~deb_dly_q;
      1:       edge_evt = ~deb_q & deb_dly_q;
      default: edge_evt = deb_q ^ deb_dly_q;
    endcase

    w1c       = (we && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    irqmask_d = (we && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;
    // Set has priority over a same-cycle clear.
    edgecap_d = (edgecap_q & ~w1c) | edge_evt;

    case (address)
      2'd0:    readdata_d = 32'(deb_q);
      2'd2:    readdata_d = 32'(irqmask_q);
      2'd3:    readdata_d = 32'(edgecap_q);
      default: readdata_d = '0;
    endcase

    if (IRQ_TYPE == 0) irq_d = |(deb_q & irqmask_q);
    else               irq_d = |(edgecap_q & irqmask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_q      <= '0;
      deb_dly_q  <= '0;
      irqmask_q  <= RESET_IRQMASK[WIDTH-1:0];
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_dly_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_pio_input_irq.sv
// Directed bench for pio_input_irq (WIDTH=4, 16-cycle debounce, rising edges,
// edge-sourced interrupt); read expectations go through a queue.
module tb_pio_input_irq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = '0;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pio_input_irq #(
    .WIDTH(4), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(0), .IRQ_TYPE(1),
    .RESET_IRQMASK(32'h0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an address, queue the expected word, take it off one edge later.
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    address = a;
    exp_q.push_back(exp);
    tick(1);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%h expected=queue_entry", tag, readdata);
    end else begin
      e = exp_q.pop_front();
      check(tag, readdata, e);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;
    tick(1);
    rd(2'd0, 32'h0, "rst_data");
    rd(2'd1, 32'h0, "rst_rsvd");
    rd(2'd2, 32'h0, "rst_irqmask");
    rd(2'd3, 32'h0, "rst_edgecap");

    // Step-to-data latency: deb moves 18 edges after the step, readdata one later
    address = 2'd0;
    in_port = 4'b0101;
    tick(17);
    rd(2'd0, 32'h0, "lat_edge18");
    rd(2'd0, 32'h5, "lat_edge19");
    tick(2);
    rd(2'd3, 32'h5, "edgecap_rise01");
    wr(2'd3, 32'hF);
    rd(2'd3, 32'h0, "edgecap_w1c_all");

    // Short pulses on bit 1 never qualify
    for (int p = 0; p < 4; p++) begin
      in_port = 4'b0111;
      tick(3);
      in_port = 4'b0101;
      tick(17);
    end
    rd(2'd0, 32'h5, "pulse_data");
    rd(2'd3, 32'h0, "pulse_edgecap");

    // Falling edges never set; rising bit 2 does; repeat keeps it set
    in_port = 4'b0000;
    tick(22);
    rd(2'd0, 32'h0, "fall_data");
    rd(2'd3, 32'h0, "fall_no_set");
    in_port = 4'b0100;
    tick(22);
    rd(2'd3, 32'h4, "rise_bit2");
    in_port = 4'b0000;
    tick(22);
    in_port = 4'b0100;
    tick(22);
    rd(2'd3, 32'h4, "rise_bit2_again");
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h0, "w1c_bit2");

    // Edge interrupt timing and masking
    wr(2'd2, 32'h4);
    rd(2'd2, 32'h4, "irqmask_rd");
    in_port = 4'b0000;
    tick(22);
    check("irq_idle", {31'h0, irq}, 32'h0);
    address = 2'd3;
    in_port = 4'b0100;
    tick(18);
    rd(2'd3, 32'h0, "edgecap_before");
    check("irq_edge19", {31'h0, irq}, 32'h0);
    rd(2'd3, 32'h4, "edgecap_set");
    check("irq_edge20", {31'h0, irq}, 32'h1);
    wr(2'd2, 32'h0);
    check("irq_at_mask_write", {31'h0, irq}, 32'h1);
    tick(1);
    check("irq_after_mask", {31'h0, irq}, 32'h0);
    rd(2'd3, 32'h4, "edgecap_kept");

    // Set beats clear in the same cycle
    in_port = 4'b0000;
    tick(22);
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h0, "pre_race_clear");
    in_port = 4'b0100;
    tick(18);
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h4, "set_beats_clear");
    wr(2'd3, 32'hFFFF_FFF0);
    rd(2'd3, 32'h4, "w1c_upper_bits");
    wr(2'd2, 32'hFFFF_FFF0);
    rd(2'd2, 32'h0, "irqmask_upper_bits");
    wr(2'd0, 32'hF);
    rd(2'd0, 32'h4, "data_ro");
    wr(2'd1, 32'hF);
    rd(2'd1, 32'h0, "rsvd_ro");

    // Reset mid-debounce
    wr(2'd2, 32'h4);
    tick(1);
    check("irq_pre_reset", {31'h0, irq}, 32'h1);
    in_port = 4'b0000;
    tick(22);
    address = 2'd0;
    in_port = 4'b0100;
    tick(12);
    reset_n = 1'b0;
    #1;
    check("async_rst_readdata", readdata, 32'h0);
    check("async_rst_irq", {31'h0, irq}, 32'h0);
    address = 2'd3;
    tick(2);
    reset_n = 1'b1;
    rd(2'd3, 32'h0, "post_rst_edgecap");
    address = 2'd0;
    tick(16);
    rd(2'd0, 32'h0, "post_rst_edge18");
    rd(2'd0, 32'h4, "post_rst_edge19");
    rd(2'd2, 32'h0, "post_rst_irqmask");
    check("post_rst_irq", {31'h0, irq}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
